// File: rtl/mult_div_unit.sv
// Shared iterative multiply/divide engine producing the HI/LO pair for the multicycle CPU.
// Operands are reduced to magnitudes at accept, processed one bit per clock, then sign-corrected.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_ZERO = 3'd4;

  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH:0]     ONE_X   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_isDiv;
  logic               r_negRes;
  logic               r_negRem;
  logic [WIDTH:0]     r_opnd;
  logic [2*WIDTH:0]   r_acc;

  logic               w_signed;
  logic               w_negA;
  logic               w_negB;
  logic [WIDTH:0]     w_extA;
  logic [WIDTH:0]     w_extB;
  logic [WIDTH:0]     w_magA;
  logic [WIDTH:0]     w_magB;
  logic [WIDTH+1:0]   w_mulSum;
  logic [2*WIDTH:0]   w_mulNext;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH+1:0]   w_divDiff;
  logic               w_qBit;
  logic [2*WIDTH:0]   w_divNext;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  // One extra bit keeps |most-negative| exact for signed operands.
  assign w_signed = ~op[0];
  assign w_negA   = w_signed & a[WIDTH-1];
  assign w_negB   = w_signed & b[WIDTH-1];
  assign w_extA   = {w_negA, a};
  assign w_extB   = {w_negB, b};
  assign w_magA   = w_negA ? (~w_extA + ONE_X) : w_extA;
  assign w_magB   = w_negB ? (~w_extB + ONE_X) : w_extB;

  // Multiply: r_acc = {partial(W+1), multiplier(W)}, add-then-shift-right.
  assign w_mulSum  = {1'b0, r_acc[2*WIDTH:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {remainder(W+1), dividend/quotient(W)}, restoring step.
  assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_divDiff  = {1'b0, w_remShift} - {1'b0, r_opnd};
  assign w_qBit     = ~w_divDiff[WIDTH+1];
  assign w_divNext  = {(w_qBit ? w_divDiff[WIDTH:0] : w_remShift), r_acc[WIDTH-2:0], w_qBit};

  assign w_prod    = r_acc[2*WIDTH-1:0];
  assign w_prodFix = r_negRes ? (~w_prod + ONE_2W) : w_prod;
  assign w_quo     = r_acc[WIDTH-1:0];
  assign w_rem     = r_acc[2*WIDTH-1:WIDTH];
  assign w_quoFix  = r_negRes ? (~w_quo + ONE_W) : w_quo;
  assign w_remFix  = r_negRem ? (~w_rem + ONE_W) : w_rem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_isDiv  <= 1'b0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            r_cnt    <= '0;
            r_isDiv  <= op[1];
            r_negRes <= w_negA ^ w_negB;
            r_negRem <= w_negA;
            if (!op[1]) begin
              r_state <= S_MUL;
              r_opnd  <= w_magA;
              r_acc   <= {{(WIDTH+1){1'b0}}, w_magB[WIDTH-1:0]};
            end else if (b == '0) begin
              r_state <= S_ZERO;
              r_opnd  <= w_magB;
              r_acc   <= {{(WIDTH+1){1'b0}}, a};
            end else begin
              r_state <= S_DIV;
              r_opnd  <= w_magB;
              r_acc   <= {{(WIDTH+1){1'b0}}, w_magA[WIDTH-1:0]};
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mulNext;
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= w_divNext;
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_isDiv) begin
            hi <= w_remFix;
            lo <= w_quoFix;
          end else begin
            hi <= w_prodFix[2*WIDTH-1:WIDTH];
            lo <= w_prodFix[WIDTH-1:0];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        // Divide by zero returns the raw dividend in hi, captured in r_acc at accept.
        S_ZERO: begin
          hi       <= r_acc[WIDTH-1:0];
          lo       <= '1;
          div_zero <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
